// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, register-file write port and hazard-mask bundle for
// regfile_write_arbiter. The slave side is the arbiter; the master side is its environment.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              hold;
  logic              flush;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [(2**ADDR_W)-1:0] pend_mask;

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  hold, flush,
    output req0_ready, req1_ready,
    output rf_we, rf_rd, rf_wdata, pend_mask
  );

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output hold, flush,
    input  req0_ready, req1_ready,
    input  rf_we, rf_rd, rf_wdata, pend_mask
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a one-entry
// output stage, x0 write suppression and a pending-write mask for hazard checks.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  regfile_write_arbiter_if.slave  bus
);
  localparam int NREG = 2**ADDR_W;

  logic              r_full;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic w_can_accept;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rd_nz;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NREG-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // reset_n gates the grants so no ready can leak out while the block is held in reset
  assign w_can_accept = reset_n && !bus.flush && (!r_full || !bus.hold);
  assign w_gnt0 = w_can_accept && bus.req0_valid && (!bus.req1_valid ||  r_last);
  assign w_gnt1 = w_can_accept && bus.req1_valid && (!bus.req0_valid || !r_last);

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
      r_last <= 1'b1;
    end else if (bus.flush) begin
      r_full <= 1'b0;
    end else if (w_gnt0 || w_gnt1) begin
      r_full <= 1'b1;
      r_rd   <= w_gnt1 ? bus.req1_rd   : bus.req0_rd;
      r_data <= w_gnt1 ? bus.req1_data : bus.req0_data;
      r_last <= w_gnt1;
    end else if (r_full && !bus.hold) begin
      r_full <= 1'b0;
    end
  end

  // Output stage: x0 entries occupy the slot but never write or mark a hazard
  assign w_rd_nz       = (r_rd != '0);
  assign bus.rf_we     = r_full && !bus.hold && w_rd_nz;
  assign bus.rf_rd     = r_rd;
  assign bus.rf_wdata  = r_data;
  assign bus.pend_mask = (r_full && w_rd_nz) ? onehot(r_rd) : '0;
endmodule
